// File: rtl/dino_pkg.sv
// Shared dino game definitions: vertical-motion state encoding and default
// physics constants, used by the jump controller, renderer and collision logic.
package dino_pkg;

  localparam int unsigned DEF_Y_W      = 8;
  localparam int unsigned DEF_V0       = 12;
  localparam int unsigned DEF_GRAVITY  = 1;
  localparam int unsigned DEF_MAX_Y    = 200;
  localparam int unsigned DEF_MAX_FALL = 15;

  localparam logic [1:0] ST_GROUND  = 2'b00;
  localparam logic [1:0] ST_ASCEND  = 2'b01;
  localparam logic [1:0] ST_DESCEND = 2'b10;

  typedef enum logic [1:0] {
    GROUND  = ST_GROUND,
    ASCEND  = ST_ASCEND,
    DESCEND = ST_DESCEND
  } dino_state_e;

endpackage

// File: rtl/dino_jump_ctrl.sv
// Dino vertical motion: latches a jump press on the ground, then runs
// take-off, ascent under gravity, descent and landing on unfrozen frame ticks.
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned V0       = DEF_V0,
  parameter int unsigned GRAVITY  = DEF_GRAVITY,
  parameter int unsigned MAX_Y    = DEF_MAX_Y,
  parameter int unsigned MAX_FALL = DEF_MAX_FALL
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_tick,
  input  logic           i_jump,
  input  logic           i_freeze,
  output logic [Y_W-1:0] o_dino_y,
  output logic           o_airborne,
  output logic           o_land,
  output logic [1:0]     o_state
);

  localparam logic [Y_W-1:0] V0_C       = Y_W'(V0);
  localparam logic [Y_W-1:0] GRAVITY_C  = Y_W'(GRAVITY);
  localparam logic [Y_W:0]   MAX_Y_X    = (Y_W+1)'(MAX_Y);
  localparam logic [Y_W:0]   MAX_FALL_X = (Y_W+1)'(MAX_FALL);

  // Sum computed one bit wider so the ceiling compare cannot wrap.
  function automatic logic [Y_W-1:0] sat_add(input logic [Y_W-1:0] a,
                                             input logic [Y_W-1:0] b,
                                             input logic [Y_W:0]   lim);
    logic [Y_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? Y_W'(lim) : Y_W'(sum);
  endfunction

  function automatic logic [Y_W-1:0] sat_sub(input logic [Y_W-1:0] a,
                                             input logic [Y_W-1:0] b);
    return (a > b) ? Y_W'(a - b) : '0;
  endfunction

  dino_state_e    state_q, state_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W-1:0] vel_q, vel_d;
  logic [Y_W-1:0] fall_q, fall_d;
  logic           pend_q, pend_d;
  logic           land_q, land_d;
  logic           air_q, air_d;
  logic [Y_W-1:0] fall_next;
  logic           step;
  logic           state_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= GROUND;
      y_q     <= '0;
      vel_q   <= '0;
      fall_q  <= '0;
      pend_q  <= 1'b0;
      land_q  <= 1'b0;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      land_q  <= land_d;
      air_q   <= air_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    vel_d     = vel_q;
    fall_d    = fall_q;
    pend_d    = pend_q;
    land_d    = 1'b0;
    step      = i_tick & ~i_freeze;
    fall_next = sat_add(fall_q, GRAVITY_C, MAX_FALL_X);
    state_ok  = (state_q == GROUND) || (state_q == ASCEND) ||
                (state_q == DESCEND);

    if (!state_ok) begin
      // Unreachable encoding: fall back to a clean grounded dino.
      state_d = GROUND;
      y_d     = '0;
      vel_d   = '0;
      fall_d  = '0;
      pend_d  = 1'b0;
    end else if (i_freeze) begin
      pend_d = 1'b0;
    end else if (step) begin
      case (state_q)
        GROUND: begin
          if (pend_q || i_jump) begin
            state_d = ASCEND;
            vel_d   = V0_C;
            y_d     = '0;
            pend_d  = 1'b0;
          end
        end
        ASCEND: begin
          y_d = sat_add(y_q, vel_q, MAX_Y_X);
          if (vel_q <= GRAVITY_C) begin
            state_d = DESCEND;
            fall_d  = '0;
          end else begin
            vel_d = vel_q - GRAVITY_C;
          end
        end
        DESCEND: begin
          if (fall_next >= y_q) begin
            state_d = GROUND;
            y_d     = '0;
            land_d  = 1'b1;
          end else begin
            y_d    = sat_sub(y_q, fall_next);
            fall_d = fall_next;
          end
        end
        default: begin
          state_d = GROUND;
          y_d     = '0;
        end
      endcase
    end else if (state_q == GROUND && i_jump) begin
      pend_d = 1'b1;
    end

    air_d = (state_d == ASCEND) || (state_d == DESCEND);
  end

  assign o_dino_y   = y_q;
  assign o_airborne = air_q;
  assign o_land     = land_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: two instances (tall ceiling / low ceiling with
// slow terminal fall) sharing stimulus, checked against a behavioural model.
module tb_dino_jump_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic tick, jump, freeze;

  logic [7:0] dy   [2];
  logic       air  [2];
  logic       land [2];
  logic [1:0] st   [2];

  always #5 clk = ~clk;

  dino_jump_ctrl #(.Y_W(8), .V0(4), .GRAVITY(1), .MAX_Y(200), .MAX_FALL(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_jump(jump), .i_freeze(freeze),
    .o_dino_y(dy[0]), .o_airborne(air[0]), .o_land(land[0]), .o_state(st[0])
  );

  dino_jump_ctrl #(.Y_W(8), .V0(4), .GRAVITY(1), .MAX_Y(8), .MAX_FALL(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_jump(jump), .i_freeze(freeze),
    .o_dino_y(dy[1]), .o_airborne(air[1]), .o_land(land[1]), .o_state(st[1])
  );

  // Reference model: phase 0 on ground, 1 rising, 2 falling.
  int p_v0   [2] = '{4, 4};
  int p_maxy [2] = '{200, 8};
  int p_maxf [2] = '{15, 2};
  int p_g        = 1;

  int m_ph [2];
  int m_y  [2];
  int m_v  [2];
  int m_f  [2];
  bit m_pend [2];
  bit m_land [2];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_y[k] = 0; m_v[k] = 0; m_f[k] = 0;
      m_pend[k] = 0; m_land[k] = 0;
    end
  endtask

  task automatic model_step(input bit t, input bit j, input bit f);
    int nf;
    for (int k = 0; k < 2; k++) begin
      m_land[k] = 0;
      if (f) m_pend[k] = 0;
      else if (t) begin
        if (m_ph[k] == 0) begin
          if (m_pend[k] || j) begin
            m_ph[k] = 1; m_v[k] = p_v0[k]; m_pend[k] = 0;
          end
        end else if (m_ph[k] == 1) begin
          m_y[k] = imin(m_y[k] + m_v[k], p_maxy[k]);
          if (m_v[k] <= p_g) begin m_ph[k] = 2; m_f[k] = 0; end
          else m_v[k] = m_v[k] - p_g;
        end else begin
          nf = imin(m_f[k] + p_g, p_maxf[k]);
          if (nf >= m_y[k]) begin m_y[k] = 0; m_ph[k] = 0; m_land[k] = 1; end
          else begin m_y[k] = m_y[k] - nf; m_f[k] = nf; end
        end
      end else if (j && m_ph[k] == 0) m_pend[k] = 1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("y%0d", k),     32'(dy[k]),   32'(m_y[k]));
      chk($sformatf("state%0d", k), 32'(st[k]),   32'(m_ph[k]));
      chk($sformatf("air%0d", k),   32'(air[k]),  32'(m_ph[k] != 0));
      chk($sformatf("land%0d", k),  32'(land[k]), 32'(m_land[k]));
    end
  endtask

  task automatic cycle(input bit t, input bit j, input bit f);
    tick = t; jump = j; freeze = f;
    @(posedge clk);
    model_step(t, j, f);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
  endtask

  int exp_full [9] = '{0, 4, 7, 9, 10, 9, 7, 4, 0};
  int exp_sat  [9] = '{0, 4, 7, 8, 8, 7, 5, 3, 1};
  int exp_rel  [5] = '{10, 9, 7, 4, 0};

  initial begin
    rst_n = 1'b0; tick = 1'b0; jump = 1'b0; freeze = 1'b0;
    model_reset();
    #2 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Full jump and low-ceiling saturation.
    cycle(0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(1, 0, 0);
      chk("full_y", 32'(dy[0]), 32'(exp_full[i]));
      chk("sat_y",  32'(dy[1]), 32'(exp_sat[i]));
    end
    chk("full_land", 32'(land[0]), 32'd1);
    cycle(1, 0, 0);
    chk("full_land_drop", 32'(land[0]), 32'd0);
    chk("sat_land", 32'(land[1]), 32'd1);
    cycle(0, 0, 0);

    // Same-cycle jump+tick, then jumps mid-air are discarded.
    cycle(1, 1, 0);
    chk("same_cycle_state", 32'(st[0]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0);
      cycle(1, 0, 0);
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("no_rejump_state", 32'(st[0]), 32'd0);
    chk("no_rejump_y", 32'(dy[0]), 32'd0);

    // Freeze mid-air at y=9.
    cycle(0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    chk("pre_freeze_y", 32'(dy[0]), 32'd9);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1);
      cycle(0, 1, 1);
      chk("frozen_y", 32'(dy[0]), 32'd9);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0);
      chk("resume_y", 32'(dy[0]), 32'(exp_rel[i]));
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);

    // Asynchronous reset mid-ascent at y=7.
    cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("pre_reset_y", 32'(dy[0]), 32'd7);
    async_reset();
    chk("reset_y", 32'(dy[0]), 32'd0);
    chk("reset_state", 32'(st[0]), 32'd0);
    chk("reset_air", 32'(air[0]), 32'd0);
    chk("reset_land", 32'(land[0]), 32'd0);

    // Jump while frozen is dropped.
    cycle(0, 1, 1);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("frozen_jump_state", 32'(st[0]), 32'd0);
    cycle(1, 0, 0);
    chk("frozen_jump_state2", 32'(st[1]), 32'd0);

    // Randomized traffic against the model.
    begin
      bit frz = 1'b0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 19) == 0) frz = ~frz;
        if ($urandom_range(0, 599) == 0) async_reset();
        else cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, frz);
      end
    end

    tick = 1'b0; jump = 1'b0; freeze = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
